// File: rtl/fpdiv_ctrl.sv
// Sequencing controller for a Goldschmidt single-precision divide datapath.
// Holds operands, steps the datapath through its multiply steps, and returns the result.
module fpdiv_ctrl #(
  parameter int ITER    = 3,
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_num,
  input  logic [31:0] in_denom,
  input  logic        in_rm,
  output logic [31:0] dp_num,
  output logic [31:0] dp_denom,
  output logic        dp_rm,
  output logic        en_a,
  output logic        en_b,
  output logic        en_rem,
  output logic [1:0]  sel_mux3,
  output logic [1:0]  sel_mux4,
  input  logic [31:0] dp_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_dz,
  output logic        out_nv
);

  localparam int ITER_W = $clog2(ITER + 1);
  localparam int STEP_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LA0, S_LB0, S_ITA, S_ITB, S_REM, S_CAP, S_SPEC, S_DONE
  } state_t;

  typedef struct packed {
    logic        special;
    logic [31:0] result;
    logic        dz;
    logic        nv;
  } cls_t;

  // Denormals have a zero exponent and are deliberately folded into the zero class.
  function automatic cls_t classify(input logic [31:0] num, input logic [31:0] denom);
    cls_t r;
    logic sign, n_nan, n_inf, n_zero, d_nan, d_inf, d_zero;
    sign   = num[31] ^ denom[31];
    n_nan  = (num[30:23] == 8'hFF) && (num[22:0] != 23'd0);
    n_inf  = (num[30:23] == 8'hFF) && (num[22:0] == 23'd0);
    n_zero = (num[30:23] == 8'h00);
    d_nan  = (denom[30:23] == 8'hFF) && (denom[22:0] != 23'd0);
    d_inf  = (denom[30:23] == 8'hFF) && (denom[22:0] == 23'd0);
    d_zero = (denom[30:23] == 8'h00);
    r = '0;
    if (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf)) begin
      r.special = 1'b1;
      r.result  = 32'h7FC0_0000;
      r.nv      = 1'b1;
    end else if (n_inf) begin
      r.special = 1'b1;
      r.result  = {sign, 8'hFF, 23'd0};
    end else if (d_zero) begin
      r.special = 1'b1;
      r.result  = {sign, 8'hFF, 23'd0};
      r.dz      = 1'b1;
    end else if (n_zero || d_inf) begin
      r.special = 1'b1;
      r.result  = {sign, 31'd0};
    end
    return r;
  endfunction

  state_t              state_reg, state_next;
  logic [STEP_W-1:0]   step_cnt_reg;
  logic [ITER_W-1:0]   iter_cnt_reg;
  logic [31:0]         spec_res_reg;
  logic                spec_dz_reg;
  logic                spec_nv_reg;

  cls_t in_cls;
  logic accept;
  logic step_state;
  logic step_last;
  logic last_iter;

  assign in_cls     = classify(in_num, in_denom);
  assign in_ready   = (state_reg == S_IDLE);
  assign accept     = in_valid && in_ready;
  assign step_state = state_reg inside {S_LA0, S_LB0, S_ITA, S_ITB, S_REM};
  assign step_last  = (step_cnt_reg == STEP_W'(MUL_LAT - 1));
  assign last_iter  = (iter_cnt_reg == ITER_W'(ITER - 1));

  always_comb begin
    state_next = state_reg;
    en_a       = 1'b0;
    en_b       = 1'b0;
    en_rem     = 1'b0;
    sel_mux3   = 2'd0;
    sel_mux4   = 2'd0;
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = in_cls.special ? S_SPEC : S_LA0;
      end
      S_LA0: begin
        en_a = step_last;
        if (step_last) state_next = S_LB0;
      end
      S_LB0: begin
        sel_mux4 = 2'd1;
        en_b     = step_last;
        if (step_last) state_next = S_ITA;
      end
      // A must be refined before B: the B/C enable overwrites the C used by both.
      S_ITA: begin
        sel_mux3 = 2'd1;
        sel_mux4 = 2'd2;
        en_a     = step_last;
        if (step_last) state_next = S_ITB;
      end
      S_ITB: begin
        sel_mux3 = 2'd1;
        sel_mux4 = 2'd3;
        en_b     = step_last;
        if (step_last) state_next = last_iter ? S_REM : S_ITA;
      end
      S_REM: begin
        sel_mux3 = 2'd2;
        sel_mux4 = 2'd2;
        en_rem   = step_last;
        if (step_last) state_next = S_CAP;
      end
      S_CAP:  state_next = S_DONE;
      S_SPEC: state_next = S_DONE;
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      step_cnt_reg <= '0;
      iter_cnt_reg <= '0;
      spec_res_reg <= '0;
      spec_dz_reg  <= 1'b0;
      spec_nv_reg  <= 1'b0;
      dp_num       <= '0;
      dp_denom     <= '0;
      dp_rm        <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_dz       <= 1'b0;
      out_nv       <= 1'b0;
    end else begin
      state_reg <= state_next;

      if ((state_next != state_reg) || !step_state)
        step_cnt_reg <= '0;
      else
        step_cnt_reg <= step_cnt_reg + STEP_W'(1);

      if (state_reg == S_IDLE)
        iter_cnt_reg <= '0;
      else if ((state_reg == S_ITB) && step_last)
        iter_cnt_reg <= iter_cnt_reg + ITER_W'(1);

      if (accept) begin
        dp_num       <= in_num;
        dp_denom     <= in_denom;
        dp_rm        <= in_rm;
        spec_res_reg <= in_cls.result;
        spec_dz_reg  <= in_cls.dz;
        spec_nv_reg  <= in_cls.nv;
      end

      case (state_reg)
        S_CAP: begin
          out_result <= dp_result;
          out_dz     <= 1'b0;
          out_nv     <= 1'b0;
          out_valid  <= 1'b1;
        end
        S_SPEC: begin
          out_result <= spec_res_reg;
          out_dz     <= spec_dz_reg;
          out_nv     <= spec_nv_reg;
          out_valid  <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed self-checking bench for fpdiv_ctrl: default instance plus a MUL_LAT=3, ITER=2 instance.
// The datapath is stood in for by a bench-driven dp_result holding the hand-computed quotient.
module tb_fpdiv_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic        in_valid = 0, in_rm = 0, out_ready = 0;
  logic [31:0] in_num = 0, in_denom = 0, dp_result = 0;
  logic        in_ready, dp_rm, en_a, en_b, en_rem, out_valid, out_dz, out_nv;
  logic [1:0]  sel_mux3, sel_mux4;
  logic [31:0] dp_num, dp_denom, out_result;

  logic        p_in_valid = 0, p_in_rm = 0, p_out_ready = 0;
  logic [31:0] p_in_num = 0, p_in_denom = 0, p_dp_result = 0;
  logic        p_in_ready, p_dp_rm, p_en_a, p_en_b, p_en_rem, p_out_valid, p_out_dz, p_out_nv;
  logic [1:0]  p_sel_mux3, p_sel_mux4;
  logic [31:0] p_dp_num, p_dp_denom, p_out_result;

  fpdiv_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_num(in_num), .in_denom(in_denom), .in_rm(in_rm),
    .dp_num(dp_num), .dp_denom(dp_denom), .dp_rm(dp_rm),
    .en_a(en_a), .en_b(en_b), .en_rem(en_rem), .sel_mux3(sel_mux3), .sel_mux4(sel_mux4),
    .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dz(out_dz), .out_nv(out_nv)
  );

  fpdiv_ctrl #(.ITER(2), .MUL_LAT(3)) dut_p (
    .clk(clk), .reset(reset), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_num(p_in_num), .in_denom(p_in_denom), .in_rm(p_in_rm),
    .dp_num(p_dp_num), .dp_denom(p_dp_denom), .dp_rm(p_dp_rm),
    .en_a(p_en_a), .en_b(p_en_b), .en_rem(p_en_rem), .sel_mux3(p_sel_mux3), .sel_mux4(p_sel_mux4),
    .dp_result(p_dp_result), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_result(p_out_result), .out_dz(p_out_dz), .out_nv(p_out_nv)
  );

  // {in_ready,out_valid,en_a,en_b,en_rem,sel_mux3,sel_mux4,out_dz,out_nv,dp_rm}
  function automatic logic [11:0] ctl_vec();
    return {in_ready, out_valid, en_a, en_b, en_rem, sel_mux3, sel_mux4, out_dz, out_nv, dp_rm};
  endfunction

  function automatic logic [6:0] step_vec();
    return {en_a, en_b, en_rem, sel_mux3, sel_mux4};
  endfunction

  // Presents one operand pair; returns at E0+#1 with in_valid dropped.
  task automatic accept_op(input logic [31:0] num, input logic [31:0] denom,
                           input logic rm, input logic [31:0] res);
    dp_result = res;
    in_num    = num;
    in_denom  = denom;
    in_rm     = rm;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  // Counts edges from E0 until out_valid, bounded.
  task automatic wait_result(output int edges);
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (ctl_vec() !== 12'h800) begin
      n_err++; $display("FAIL reset_ctl got=%h want=%h", ctl_vec(), 12'h800);
    end
    n_cmp++;
    if ({dp_num, dp_denom, out_result} !== 96'd0) begin
      n_err++; $display("FAIL reset_data got=%h %h %h want=0", dp_num, dp_denom, out_result);
    end
    n_cmp++;
    if ({p_in_ready, p_out_valid, p_en_a, p_en_b, p_en_rem} !== 5'b10000) begin
      n_err++; $display("FAIL reset_p got=%b want=10000", {p_in_ready, p_out_valid, p_en_a, p_en_b, p_en_rem});
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    int e;
    accept_op(32'h40C0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000);
    wait_result(e);
    $display("txn 6/2: result=%h dz=%b nv=%b latency=%0d", out_result, out_dz, out_nv, e);
    n_cmp++;
    if (e !== 10) begin n_err++; $display("FAIL normal_latency got=%0d want=10", e); end
    n_cmp++;
    if (out_result !== 32'h4040_0000) begin
      n_err++; $display("FAIL normal_result got=%h want=40400000", out_result);
    end
    n_cmp++;
    if ({out_dz, out_nv, in_ready} !== 3'b000) begin
      n_err++; $display("FAIL normal_flags got=%b want=000", {out_dz, out_nv, in_ready});
    end
    n_cmp++;
    if ({dp_num, dp_denom, dp_rm} !== {32'h40C0_0000, 32'h4000_0000, 1'b1}) begin
      n_err++; $display("FAIL normal_hold got=%h %h %b want=40c00000 40000000 1", dp_num, dp_denom, dp_rm);
    end
    release_result();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL normal_release got=%b want=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_trace();
    logic [6:0] exp_tr [11];
    int e;
    exp_tr[0] = 7'b100_00_00; exp_tr[1] = 7'b010_00_01;
    exp_tr[2] = 7'b100_01_10; exp_tr[3] = 7'b010_01_11;
    exp_tr[4] = 7'b100_01_10; exp_tr[5] = 7'b010_01_11;
    exp_tr[6] = 7'b100_01_10; exp_tr[7] = 7'b010_01_11;
    exp_tr[8] = 7'b001_10_10; exp_tr[9] = 7'b000_00_00;
    exp_tr[10] = 7'b000_00_00;
    accept_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h3F00_0000);
    for (int j = 0; j < 11; j++) begin
      n_cmp++;
      if ({step_vec(), out_valid} !== {exp_tr[j], (j == 10)}) begin
        n_err++; $display("FAIL trace_cycle%0d got=%b want=%b", j, {step_vec(), out_valid}, {exp_tr[j], (j == 10)});
      end
      if (j < 10) begin @(posedge clk); #1; end
    end
    wait_result(e);
    $display("txn 1/2: result=%h dz=%b nv=%b", out_result, out_dz, out_nv);
    n_cmp++;
    if (out_result !== 32'h3F00_0000) begin
      n_err++; $display("FAIL trace_result got=%h want=3f000000", out_result);
    end
    release_result();
  endtask

  task automatic test_special();
    logic [97:0] tab [11];
    logic [31:0] num, denom, res;
    logic [1:0]  fl;
    int e;
    tab[0]  = {32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 2'b10};
    tab[1]  = {32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 2'b01};
    tab[2]  = {32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 2'b10};
    tab[3]  = {32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 2'b00};
    tab[4]  = {32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 2'b01};
    tab[5]  = {32'h0000_0000, 32'hC040_0000, 32'h8000_0000, 2'b00};
    tab[6]  = {32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 2'b00};
    tab[7]  = {32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 2'b01};
    tab[8]  = {32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 2'b00};
    tab[9]  = {32'h4000_0000, 32'h0000_0001, 32'h7F80_0000, 2'b10};
    tab[10] = {32'hFF80_0000, 32'h0000_0000, 32'hFF80_0000, 2'b00};
    for (int i = 0; i < 11; i++) begin
      num = tab[i][97:66]; denom = tab[i][65:34]; res = tab[i][33:2]; fl = tab[i][1:0];
      accept_op(num, denom, 1'b0, 32'hDEAD_BEEF);
      n_cmp++;
      if ({step_vec(), out_valid} !== 8'd0) begin
        n_err++; $display("FAIL special%0d_ctl got=%b want=0", i, {step_vec(), out_valid});
      end
      wait_result(e);
      $display("txn %h/%h: result=%h dz=%b nv=%b latency=%0d", num, denom, out_result, out_dz, out_nv, e);
      n_cmp++;
      if (e !== 1) begin n_err++; $display("FAIL special%0d_latency got=%0d want=1", i, e); end
      n_cmp++;
      if (out_result !== res) begin
        n_err++; $display("FAIL special%0d_result got=%h want=%h", i, out_result, res);
      end
      n_cmp++;
      if ({out_dz, out_nv} !== fl) begin
        n_err++; $display("FAIL special%0d_flags got=%b want=%b", i, {out_dz, out_nv}, fl);
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    int e;
    accept_op(32'h40C0_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
    wait_result(e);
    in_num = 32'h1111_1111; in_denom = 32'h2222_2222; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if ({out_valid, in_ready, out_result} !== {2'b10, 32'h4040_0000}) begin
        n_err++; $display("FAIL stall%0d got=%b%b %h want=10 40400000", k, out_valid, in_ready, out_result);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (dp_num !== 32'h40C0_0000) begin
      n_err++; $display("FAIL stall_ignored got=%h want=40c00000", dp_num);
    end
    in_num = 32'h4120_0000; in_denom = 32'h40A0_0000; dp_result = 32'h4000_0000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, dp_num} !== {2'b01, 32'h40C0_0000}) begin
      n_err++; $display("FAIL b2b_handshake got=%b%b %h want=01 40c00000", out_valid, in_ready, dp_num);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, dp_num} !== {1'b0, 32'h4120_0000}) begin
      n_err++; $display("FAIL b2b_accept got=%b %h want=0 41200000", in_ready, dp_num);
    end
    wait_result(e);
    $display("txn 10/5: result=%h latency=%0d", out_result, e);
    n_cmp++;
    if ({e, out_result} !== {32'd10, 32'h4000_0000}) begin
      n_err++; $display("FAIL b2b_result got=%0d %h want=10 40000000", e, out_result);
    end
    release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL idle_out_ready got=%b want=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid();
    int e;
    accept_op(32'h40C0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000);
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (step_vec() !== 7'b010_01_11) begin
      n_err++; $display("FAIL midreset_itb got=%b want=0100111", step_vec());
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (ctl_vec() !== 12'h800) begin
      n_err++; $display("FAIL midreset_ctl got=%h want=800", ctl_vec());
    end
    n_cmp++;
    if ({dp_num, out_result} !== 64'd0) begin
      n_err++; $display("FAIL midreset_data got=%h %h want=0", dp_num, out_result);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    accept_op(32'h40C0_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
    wait_result(e);
    $display("txn 6/2 after reset: result=%h latency=%0d", out_result, e);
    n_cmp++;
    if ({e, out_result, out_dz, out_nv} !== {32'd10, 32'h4040_0000, 2'b00}) begin
      n_err++; $display("FAIL midreset_redo got=%0d %h want=10 40400000", e, out_result);
    end
    release_result();
  endtask

  task automatic test_params();
    logic [6:0] step_tab [7];
    logic [6:0] want;
    int e;
    step_tab[0] = 7'b100_00_00; step_tab[1] = 7'b010_00_01;
    step_tab[2] = 7'b100_01_10; step_tab[3] = 7'b010_01_11;
    step_tab[4] = 7'b100_01_10; step_tab[5] = 7'b010_01_11;
    step_tab[6] = 7'b001_10_10;
    p_dp_result = 32'h4000_0000;
    p_in_num = 32'h3FC0_0000; p_in_denom = 32'h3F40_0000; p_in_valid = 1'b1;
    @(posedge clk); #1;
    p_in_valid = 1'b0;
    e = 0;
    for (int j = 0; j < 21; j++) begin
      want = step_tab[j / 3];
      if (j % 3 != 2) want[6:4] = 3'b000;
      n_cmp++;
      if ({p_en_a, p_en_b, p_en_rem, p_sel_mux3, p_sel_mux4} !== want) begin
        n_err++; $display("FAIL param_cycle%0d got=%b want=%b", j, {p_en_a, p_en_b, p_en_rem, p_sel_mux3, p_sel_mux4}, want);
      end
      @(posedge clk); #1;
      e++;
    end
    while (!p_out_valid && e < 200) begin @(posedge clk); #1; e++; end
    $display("txn 1.5/0.75 (MUL_LAT=3 ITER=2): result=%h latency=%0d", p_out_result, e);
    n_cmp++;
    if (e !== 22) begin n_err++; $display("FAIL param_latency got=%0d want=22", e); end
    n_cmp++;
    if ({p_out_result, p_out_dz, p_out_nv} !== {32'h4000_0000, 2'b00}) begin
      n_err++; $display("FAIL param_result got=%h %b%b want=40000000 00", p_out_result, p_out_dz, p_out_nv);
    end
    p_out_ready = 1'b1;
    @(posedge clk); #1;
    p_out_ready = 1'b0;
    n_cmp++;
    if ({p_out_valid, p_in_ready} !== 2'b01) begin
      n_err++; $display("FAIL param_release got=%b want=01", {p_out_valid, p_in_ready});
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_trace();
    test_special();
    test_back_to_back();
    test_reset_mid();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
